// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver. Each digit slot is a blanking
// interval followed by a lit interval. Display data is double-buffered and only
// committed at frame boundaries.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int SEG_ACT_HIGH = 1,
    parameter int DIG_ACT_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic                    load_ack,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_OFF = (SEG_ACT_HIGH != 0) ? 7'h00 : 7'h7F;
    localparam logic                  DP_OFF  = (SEG_ACT_HIGH != 0) ? 1'b0 : 1'b1;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                   : {NUM_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    frame_end;
    logic                    commit;

    logic [7*NUM_DIGITS-1:0] disp_seg_q, pend_seg_q;
    logic [NUM_DIGITS-1:0]   disp_dp_q, pend_dp_q;
    logic                    pend_vld_q;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    ack_q, tick_q;

    logic [6:0]              sel_seg;
    logic                    sel_dp;
    logic [NUM_DIGITS-1:0]   dig_onehot;
    logic                    lit;

    // Scan sequencer: the slot counter runs 0..CLK_DIV-1 across BLANK then SHOW.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        frame_end = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == BLANK_LAST) state_d = SHOW;
                end
                SHOW: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // With no scan running there is no frame boundary to wait for.
    assign commit = pend_vld_q && (frame_end || (state_q == IDLE) || !enable);

    always_comb begin
        sel_seg    = '0;
        sel_dp     = 1'b0;
        dig_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                sel_seg       = disp_seg_q[7*k +: 7];
                sel_dp        = disp_dp_q[k];
                dig_onehot[k] = 1'b1;
            end
        end
        lit   = enable && (state_q == SHOW);
        seg_d = lit ? sel_seg : 7'h00;
        dp_d  = lit ? sel_dp : 1'b0;
        dig_d = lit ? dig_onehot : '0;
        if (SEG_ACT_HIGH == 0) begin
            seg_d = ~seg_d;
            dp_d  = ~dp_d;
        end
        if (DIG_ACT_LOW != 0) dig_d = ~dig_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            disp_seg_q <= '0;
            disp_dp_q  <= '0;
            pend_seg_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
            dig_q      <= DIG_OFF;
            ack_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let a load on the commit cycle capture new
            // pending data while the display takes the previously held pending data.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            if (commit) begin
                disp_seg_q <= pend_seg_q;
                disp_dp_q  <= pend_dp_q;
            end
            if (load) begin
                pend_seg_q <= seg_in;
                pend_dp_q  <= dp_in;
            end
            pend_vld_q <= load || (pend_vld_q && !commit);
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            dig_q      <= dig_d;
            ack_q      <= commit;
            tick_q     <= frame_end;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign dig_sel    = dig_q;
    assign load_ack   = ack_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
// Outputs are sampled on the falling edge; inputs are driven there too.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [27:0] seg_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        load_ack;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  dig_sel;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    // c counts rising edges since enable was last raised (edge 0 samples enable).
    int          c;
    int          commit_at;
    logic [27:0] cur_seg, nxt_seg;
    logic [3:0]  cur_dp, nxt_dp;

    localparam logic [27:0] D3210 = {7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110};
    localparam logic [27:0] DB1   = {7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};
    localparam logic [27:0] DB2   = {7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111};
    localparam logic [27:0] DC    = {7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    localparam logic [27:0] DD    = {7'b0000001, 7'b0110111, 7'b0001110, 7'b1100111};
    localparam logic [27:0] DE    = {7'b0111110, 7'b0000110, 7'b1011011, 7'b1001111};
    localparam logic [27:0] DF    = {7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101};

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .CLK_DIV     (8),
        .BLANK_CYCLES(2),
        .SEG_ACT_HIGH(1),
        .DIG_ACT_LOW (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .seg_in    (seg_in),
        .dp_in     (dp_in),
        .load      (load),
        .load_ack  (load_ack),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .dig_sel   (dig_sel),
        .frame_tick(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [13:0] observed();
        return {dig_sel, seg_out, dp_out, frame_tick, load_ack};
    endfunction

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Fully dark outputs, with the given load_ack level.
    task automatic check_off(input string tag, input logic ack);
        check(tag, observed(), {4'b1111, 7'b0000000, 1'b0, 1'b0, ack});
    endtask

    // Step n clocks of a running scan and check every output against the hand-derived schedule:
    // after edge c (c>=1) the slot position is (c-1)%8 (lit for positions 2..7) and the digit
    // is ((c-1)/8)%4; frame_tick follows every 32nd edge; load_ack only at commit_at.
    task automatic scan_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic        lit;
            int          d;
            logic [3:0]  e_dig;
            logic [6:0]  e_seg;
            logic        e_dp;
            @(negedge clk);
            c++;
            lit   = (c >= 1) && (((c - 1) % 8) >= 2);
            d     = (c >= 1) ? ((c - 1) / 8) % 4 : 0;
            e_dig = lit ? ~(4'b0001 << d) : 4'b1111;
            e_seg = lit ? cur_seg[7*d +: 7] : 7'b0000000;
            e_dp  = lit ? cur_dp[d] : 1'b0;
            check($sformatf("scan c=%0d", c), observed(),
                  {e_dig, e_seg, e_dp, (c > 0) && (c % 32 == 0), c == commit_at});
            if (c == commit_at) begin
                cur_seg   = nxt_seg;
                cur_dp    = nxt_dp;
                commit_at = -1;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        seg_in    = '0;
        dp_in     = '0;
        commit_at = -1;
        cur_seg   = '0;
        cur_dp    = '0;
        nxt_seg   = '0;
        nxt_dp    = '0;
        c         = -1;

        // Reset state
        @(negedge clk);
        check_off("reset_state", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_off("idle_after_reset", 1'b0);

        // Plain scan, blank display: two full frames
        enable = 1'b1;
        c      = -1;
        scan_cycles(65);

        // Load "3210" during digit 2; commit coincides with frame_tick at c=96
        scan_cycles(18);
        seg_in = D3210; dp_in = 4'b0001; load = 1'b1;
        nxt_seg = D3210; nxt_dp = 4'b0001; commit_at = 96;
        scan_cycles(1);
        load = 1'b0;
        scan_cycles(45);

        // Two loads in one frame: last one wins, single ack at c=160
        scan_cycles(7);
        seg_in = DB1; dp_in = 4'b1000; load = 1'b1;
        nxt_seg = DB1; nxt_dp = 4'b1000; commit_at = 160;
        scan_cycles(1);
        load = 1'b0;
        scan_cycles(9);
        seg_in = DB2; dp_in = 4'b0100; load = 1'b1;
        nxt_seg = DB2; nxt_dp = 4'b0100;
        scan_cycles(1);
        load = 1'b0;
        scan_cycles(24);

        // Load on the commit cycle: C commits at 192, D stays pending until 224
        seg_in = DC; dp_in = 4'b0010; load = 1'b1;
        nxt_seg = DC; nxt_dp = 4'b0010; commit_at = 192;
        scan_cycles(1);
        load = 1'b0;
        scan_cycles(20);
        seg_in = DD; dp_in = 4'b1001; load = 1'b1;
        scan_cycles(1);
        load = 1'b0;
        nxt_seg = DD; nxt_dp = 4'b1001; commit_at = 224;
        scan_cycles(44);

        // Enable drop mid-SHOW of digit 1 (c=236 is lit digit 1)
        enable = 1'b0;
        @(negedge clk);
        check_off("enable_drop_next", 1'b0);
        @(negedge clk);
        check_off("enable_drop_idle", 1'b0);

        // Re-enable: restarts at BLANK, digit 0, preserved data D
        enable = 1'b1;
        c      = -1;
        scan_cycles(11);

        // Load while disabled commits on the following cycle
        enable = 1'b0;
        @(negedge clk);
        check_off("disable_again", 1'b0);
        seg_in = DE; dp_in = 4'b0110; load = 1'b1;
        @(negedge clk);
        check_off("idle_load_captured", 1'b0);
        load = 1'b0;
        @(negedge clk);
        check_off("idle_load_ack", 1'b1);
        @(negedge clk);
        check_off("idle_ack_single", 1'b0);
        enable  = 1'b1;
        c       = -1;
        cur_seg = DE;
        cur_dp  = 4'b0110;
        scan_cycles(5);

        // Asynchronous reset mid-SHOW with a load pending
        seg_in = DF; dp_in = 4'b1111; load = 1'b1;
        scan_cycles(1);
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_off("async_reset_same_cycle", 1'b0);
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_off($sformatf("pending_cleared_%0d", i), 1'b0);
        end
        enable  = 1'b1;
        c       = -1;
        cur_seg = '0;
        cur_dp  = '0;
        scan_cycles(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
